// File: rtl/writeback_arbiter.sv
// ---------------------------------------------------------------------------
// writeback_arbiter
//
// Write-side front end of the register file. Register writebacks from the ALU
// and from the load unit are merged into the single RF write port, at most one
// write per cycle. Each producer has a small FIFO with a valid/ready handshake.
// When both FIFOs hold entries, a round-robin arbiter chooses between them so
// that neither producer can starve. The pending_mask output lists every
// register that has a write queued or on the RF port, so operand fetch can
// stall on it.
//
// Ports
//   clk                   rising-edge clock
//   rst                   asynchronous, active-low reset
//   alu_valid/ready       ALU writeback handshake
//   alu_dest/data         ALU destination register and result
//   mem_valid/ready       load-unit writeback handshake
//   mem_dest/data         load destination register and data
//   rf_write_enable       registered write strobe to the register file
//   rf_write_destination  registered write index to the register file
//   rf_write_data         registered write data to the register file
//   pending_mask          bit r set while a write to register r is queued or
//                         is being driven on the RF port
//
// writeback_fifo (helper, same file)
//   A circular FIFO of {dest, data} entries. It also produces a one-hot OR of
//   the destinations of all occupied entries.
// ---------------------------------------------------------------------------

module writeback_fifo #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [ADDR_W-1:0]      push_dest,
    input  logic [DATA_W-1:0]      push_data,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W-1:0]      head_dest,
    output logic [DATA_W-1:0]      head_data,
    output logic [2**ADDR_W-1:0]   occupied_mask
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  count;
    logic [ADDR_W-1:0] dest_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    // Each pointer carries one extra wrap bit. Equal pointers mean the FIFO is
    // empty. If the index bits match but the wrap bits differ, the writer is
    // one full lap ahead of the reader, so the FIFO is full.
    assign full      = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                       (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
    assign empty     = (wr_ptr == rd_ptr);
    assign count     = wr_ptr - rd_ptr;
    assign head_dest = dest_mem[rd_ptr[IDX_W-1:0]];
    assign head_data = data_mem[rd_ptr[IDX_W-1:0]];

    // Pointer bookkeeping. The pointers wrap naturally at 2**PTR_W, so a push
    // and a pop in the same cycle leave the occupancy unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // The storage needs no reset. An entry is only seen by the rest of the
    // design once the pointers say that it is occupied.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            dest_mem[wr_ptr[IDX_W-1:0]] <= push_dest;
            data_mem[wr_ptr[IDX_W-1:0]] <= push_data;
        end
    end

    // Walk the occupied slots, starting at the read pointer, and OR together
    // the one-hot form of each stored destination.
    always_comb begin
        occupied_mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (PTR_W'(k) < count) begin
                occupied_mask[dest_mem[rd_ptr[IDX_W-1:0] + IDX_W'(k)]] = 1'b1;
            end
        end
    end

endmodule

module writeback_arbiter #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [ADDR_W-1:0]      alu_dest,
    input  logic [DATA_W-1:0]      alu_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [ADDR_W-1:0]      mem_dest,
    input  logic [DATA_W-1:0]      mem_data,
    output logic                   rf_write_enable,
    output logic [ADDR_W-1:0]      rf_write_destination,
    output logic [DATA_W-1:0]      rf_write_data,
    output logic [2**ADDR_W-1:0]   pending_mask
);

    localparam int NREG = 2**ADDR_W;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    grant_t            last_grant;
    logic              alu_full, alu_empty, mem_full, mem_empty;
    logic              alu_push, mem_push;
    logic              grant_alu, grant_mem;
    logic [ADDR_W-1:0] alu_head_dest, mem_head_dest;
    logic [DATA_W-1:0] alu_head_data, mem_head_data;
    logic [NREG-1:0]   alu_occupied, mem_occupied;

    // ready depends only on FIFO state. A pop in the same cycle does not
    // free a slot early, so there is no combinational path from the arbiter
    // back to the producers.
    assign alu_ready = !alu_full;
    assign mem_ready = !mem_full;
    assign alu_push  = alu_valid && alu_ready;
    assign mem_push  = mem_valid && mem_ready;

    // Round robin. A channel that is the only one with data always wins.
    // When both channels have data, the one that did not win last time gets
    // the grant.
    assign grant_alu = !alu_empty && (mem_empty || (last_grant == GRANT_MEM));
    assign grant_mem = !mem_empty && (alu_empty || (last_grant == GRANT_ALU));

    writeback_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_alu_fifo (
        .clk           (clk),
        .rst           (rst),
        .push          (alu_push),
        .pop           (grant_alu),
        .push_dest     (alu_dest),
        .push_data     (alu_data),
        .full          (alu_full),
        .empty         (alu_empty),
        .head_dest     (alu_head_dest),
        .head_data     (alu_head_data),
        .occupied_mask (alu_occupied)
    );

    writeback_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_mem_fifo (
        .clk           (clk),
        .rst           (rst),
        .push          (mem_push),
        .pop           (grant_mem),
        .push_dest     (mem_dest),
        .push_data     (mem_data),
        .full          (mem_full),
        .empty         (mem_empty),
        .head_dest     (mem_head_dest),
        .head_data     (mem_head_data),
        .occupied_mask (mem_occupied)
    );

    // Registered output stage and round-robin state. The granted head moves
    // into the RF port registers at the same edge that pops it. In a cycle
    // with no grant, the strobe drops and dest/data keep their last values.
    // After reset last_grant is MEM, so the ALU wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_write_enable      <= 1'b0;
            rf_write_destination <= '0;
            rf_write_data        <= '0;
            last_grant           <= GRANT_MEM;
        end else if (grant_alu) begin
            rf_write_enable      <= 1'b1;
            rf_write_destination <= alu_head_dest;
            rf_write_data        <= alu_head_data;
            last_grant           <= GRANT_ALU;
        end else if (grant_mem) begin
            rf_write_enable      <= 1'b1;
            rf_write_destination <= mem_head_dest;
            rf_write_data        <= mem_head_data;
            last_grant           <= GRANT_MEM;
        end else begin
            rf_write_enable      <= 1'b0;
        end
    end

    // A register counts as pending while a write to it sits in either FIFO,
    // and also during the cycle in which that write is on the RF port.
    assign pending_mask = alu_occupied | mem_occupied |
                          (rf_write_enable ? (NREG'(1) << rf_write_destination) : '0);

endmodule
